mem_arbiter: RTL and testbench

- Shares the core's single-port synchronous SRAM between two requesters: instruction fetch (IF) and load/store unit (LS).
- Sits between the core pipeline and the unified memory macro. Grants at most one access per cycle.
- Routes the one-cycle-latency read data back to the owner and supports back-to-back issue.
- Bounds fetch starvation and lets the pipeline flush an in-flight fetch on redirect.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter_prio2.sv | 34 +++
 rtl/mem_arbiter.sv | 89 ++++++++
 tb/tb_mem_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and constants for the IF/LS single-port memory arbiter.
package mem_arbiter_pkg;

  localparam int WORD_SHIFT = 2;
  localparam int BYTE_LANES = 4;

  typedef enum logic [2:0] {
    OWN_NONE    = 3'd0,
    OWN_IF      = 3'd1,
    OWN_LS_RD   = 3'd2,
    OWN_LS_WR   = 3'd3,
    OWN_IF_DROP = 3'd4
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-macro signals of the arbiter, bundled with per-side modports.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                    if_req_valid;
  logic                    if_req_ready;
  logic [ADDR_W-1:0]       if_addr;
  logic                    if_flush;
  logic                    if_rsp_valid;
  logic [DATA_W-1:0]       if_rdata;

  logic                    ls_req_valid;
  logic                    ls_req_ready;
  logic [ADDR_W-1:0]       ls_addr;
  logic                    ls_we;
  logic [BYTE_LANES-1:0]   ls_wstrb;
  logic [DATA_W-1:0]       ls_wdata;
  logic                    ls_rsp_valid;
  logic [DATA_W-1:0]       ls_rdata;

  logic                    mem_en;
  logic [BYTE_LANES-1:0]   mem_we;
  logic [ADDR_W-3:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;

  modport slave (
    input  if_req_valid, if_addr, if_flush,
    input  ls_req_valid, ls_addr, ls_we, ls_wstrb, ls_wdata,
    input  mem_rdata,
    output if_req_ready, if_rsp_valid, if_rdata,
    output ls_req_ready, ls_rsp_valid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req_valid, if_addr, if_flush,
    output ls_req_valid, ls_addr, ls_we, ls_wstrb, ls_wdata,
    output mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rdata,
    input  ls_req_ready, ls_rsp_valid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_prio2.sv
// Two-input fixed-priority grant: LS wins by default, IF is forced once it has
// watched MAX_STARVE consecutive LS grants.
module arb_prio2 #(
  parameter int MAX_STARVE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ls_valid,
  input  logic i_if_valid,
  output logic o_ls_grant,
  output logic o_if_grant
);

  localparam logic [3:0] L_MAX = 4'(MAX_STARVE);

  logic [3:0] r_starve_cnt;
  logic       w_force_if;

  assign w_force_if = (r_starve_cnt == L_MAX);
  assign o_if_grant = i_if_valid & (~i_ls_valid | w_force_if);
  assign o_ls_grant = i_ls_valid & ~o_if_grant;

  // Counts only LS wins that IF actually had to watch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 4'd0;
    end else if (!i_if_valid || o_if_grant) begin
      r_starve_cnt <= 4'd0;
    end else if (o_ls_grant && !w_force_if) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port SRAM between instruction fetch and load/store, routing
// the one-cycle-latency read data back to whoever issued the access.
//
//   state       | meaning
//   OWN_NONE    | no access issued last cycle
//   OWN_IF      | fetch issued last cycle, response due now
//   OWN_LS_RD   | load issued last cycle, data due now
//   OWN_LS_WR   | store issued last cycle, ack due now
//   OWN_IF_DROP | fetch issued under flush, response suppressed
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  logic                  w_if_valid;
  logic                  w_ls_valid;
  logic                  w_if_grant;
  logic                  w_ls_grant;
  logic                  w_unused_lsb;
  logic [ADDR_W-3:0]     w_mem_addr;
  logic [BYTE_LANES-1:0] w_mem_we;
  logic [DATA_W-1:0]     w_mem_wdata;
  owner_e                r_owner;

  // Gating with rst_n keeps every request output low while reset is held.
  assign w_if_valid = bus.if_req_valid & rst_n;
  assign w_ls_valid = bus.ls_req_valid & rst_n;

  arb_prio2 #(
    .MAX_STARVE (MAX_STARVE)
  ) u_prio (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ls_valid (w_ls_valid),
    .i_if_valid (w_if_valid),
    .o_ls_grant (w_ls_grant),
    .o_if_grant (w_if_grant)
  );

  assign w_unused_lsb = ^{bus.if_addr[WORD_SHIFT-1:0], bus.ls_addr[WORD_SHIFT-1:0]};

  always_comb begin
    w_mem_addr  = '0;
    w_mem_we    = '0;
    w_mem_wdata = '0;
    if (w_if_grant) begin
      w_mem_addr = bus.if_addr[ADDR_W-1:WORD_SHIFT];
    end else if (w_ls_grant) begin
      w_mem_addr = bus.ls_addr[ADDR_W-1:WORD_SHIFT];
      if (bus.ls_we) begin
        w_mem_we    = bus.ls_wstrb;
        w_mem_wdata = bus.ls_wdata;
      end
    end
  end

  assign bus.if_req_ready = w_if_grant;
  assign bus.ls_req_ready = w_ls_grant;
  assign bus.mem_en       = w_if_grant | w_ls_grant;
  assign bus.mem_addr     = w_mem_addr;
  assign bus.mem_we       = w_mem_we;
  assign bus.mem_wdata    = w_mem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_NONE;
    end else if (w_if_grant) begin
      r_owner <= bus.if_flush ? OWN_IF_DROP : OWN_IF;
    end else if (w_ls_grant) begin
      r_owner <= bus.ls_we ? OWN_LS_WR : OWN_LS_RD;
    end else begin
      r_owner <= OWN_NONE;
    end
  end

  // A flush arriving in the response cycle still kills a live fetch response.
  assign bus.if_rsp_valid = (r_owner == OWN_IF) & ~bus.if_flush;
  assign bus.if_rdata     = (r_owner == OWN_IF) ? bus.mem_rdata : '0;
  assign bus.ls_rsp_valid = (r_owner == OWN_LS_RD) | (r_owner == OWN_LS_WR);
  assign bus.ls_rdata     = (r_owner == OWN_LS_RD) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter with a scoreboard for responses.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MAX_STARVE = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STARVE(MAX_STARVE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    bit          drop;
    logic [31:0] data;
  } exp_t;

  exp_t        if_q[$];
  exp_t        ls_q[$];
  logic [31:0] sram[64];
  logic [31:0] ref_mem[64];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          streak = 0;
  logic [31:0] last_ls_rdata = '0;
  logic [29:0] last_mem_addr;
  logic [3:0]  last_mem_we;
  bit          g_if;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(int i);
    return (i == 8) ? 32'h0 : (32'hA500_0000 | (32'(i) * 32'h0001_0101));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory macro: synchronous read, byte-masked write.
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we == 4'h0) bus.mem_rdata <= sram[bus.mem_addr[5:0]];
    else bus.mem_rdata <= $urandom;
    if (bus.mem_en)
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) sram[bus.mem_addr[5:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
  end

  // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic drive(bit ifv, logic [31:0] ifa, bit fl, bit lsv, logic [31:0] lsa,
                       bit we, logic [3:0] st, logic [31:0] wd);
    bit          e_if, e_ls;
    logic [29:0] e_addr;
    logic [3:0]  e_we;
    int          w;
    bus.if_req_valid = ifv;  bus.if_addr = ifa;  bus.if_flush = fl;
    bus.ls_req_valid = lsv;  bus.ls_addr = lsa;  bus.ls_we = we;
    bus.ls_wstrb = st;       bus.ls_wdata = wd;
    #1;
    e_if   = rst_n && ifv && (!lsv || streak == MAX_STARVE);
    e_ls   = rst_n && lsv && !e_if;
    e_addr = e_if ? ifa[31:2] : (e_ls ? lsa[31:2] : 30'h0);
    e_we   = (e_ls && we) ? st : 4'h0;
    chk("if_req_ready", {31'b0, bus.if_req_ready}, {31'b0, e_if});
    chk("ls_req_ready", {31'b0, bus.ls_req_ready}, {31'b0, e_ls});
    chk("mem_en", {31'b0, bus.mem_en}, {31'b0, e_if | e_ls});
    chk("mem_addr", {2'b0, bus.mem_addr}, {2'b0, e_addr});
    chk("mem_we", {28'b0, bus.mem_we}, {28'b0, e_we});
    if (e_ls && we) chk("mem_wdata", bus.mem_wdata, wd);
    if (e_if) begin
      w = int'(ifa[7:2]);
      if_q.push_back('{cyc + 1, fl, ref_mem[w]});
    end
    if (e_ls) begin
      w = int'(lsa[7:2]);
      if (we) begin
        ls_q.push_back('{cyc + 1, 1'b0, 32'h0});
        for (int b = 0; b < 4; b++) if (st[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
      end else begin
        ls_q.push_back('{cyc + 1, 1'b0, ref_mem[w]});
      end
    end
    streak        = (rst_n && ifv && e_ls) ? streak + 1 : 0;
    g_if          = bus.if_req_ready;
    last_mem_addr = bus.mem_addr;
    last_mem_we   = bus.mem_we;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(bit fl);
    drive(0, 32'h0, fl, 0, 32'h0, 0, 4'h0, 32'h0);
  endtask

  // Response monitor: pops the scoreboard whenever a response is due.
  always @(negedge clk) begin
    exp_t e;
    bit   has, ev;
    if (!rst_n) begin
      chk("rst_rsp_valid", {30'b0, bus.if_rsp_valid, bus.ls_rsp_valid}, 32'h0);
      chk("rst_rdata", bus.if_rdata | bus.ls_rdata, 32'h0);
    end else begin
      has = (if_q.size() > 0) && (if_q[0].due == cyc);
      if (has) e = if_q.pop_front();
      ev = has && !e.drop && !bus.if_flush;
      chk("if_rsp_valid", {31'b0, bus.if_rsp_valid}, {31'b0, ev});
      if (ev) chk("if_rdata", bus.if_rdata, e.data);
      has = (ls_q.size() > 0) && (ls_q[0].due == cyc);
      if (has) e = ls_q.pop_front();
      chk("ls_rsp_valid", {31'b0, bus.ls_rsp_valid}, {31'b0, has});
      if (has) begin
        chk("ls_rdata", bus.ls_rdata, e.data);
        last_ls_rdata = bus.ls_rdata;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pat;
    for (int i = 0; i < 64; i++) begin
      sram[i]    = init_word(i);
      ref_mem[i] = init_word(i);
    end
    #1;
    // Reset held with both requesters valid.
    drive(1, 32'h0, 0, 1, 32'h40, 0, 4'h0, 32'h0);
    drive(1, 32'h0, 0, 1, 32'h40, 0, 4'h0, 32'h0);
    rst_n = 1'b1;
    drive(1, 32'h0, 0, 1, 32'h40, 0, 4'h0, 32'h0);
    idle(0);
    // Single fetch.
    drive(1, 32'h10, 0, 0, 32'h0, 0, 4'h0, 32'h0);
    chk("fetch_mem_addr", {2'b0, last_mem_addr}, 32'h4);
    idle(0);
    // Continuous contention.
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'(4 * i), 0, 1, 32'(32'h80 + 4 * i), 0, 4'h0, 32'h0);
      pat[i] = g_if;
    end
    chk("contention_pattern", {22'b0, pat}, 32'h210);
    idle(0);
    // Partial store then load of the same word.
    drive(0, 32'h0, 0, 1, 32'h20, 1, 4'h3, 32'hDEADBEEF);
    chk("store_mem_we", {28'b0, last_mem_we}, 32'h3);
    drive(0, 32'h0, 0, 1, 32'h20, 0, 4'h0, 32'h0);
    idle(0);
    chk("load_after_store", last_ls_rdata, 32'h0000BEEF);
    // Flush in the response cycle, flush in the grant cycle, then an LS.
    drive(1, 32'h30, 0, 0, 32'h0, 0, 4'h0, 32'h0);
    idle(1);
    drive(1, 32'h34, 1, 0, 32'h0, 0, 4'h0, 32'h0);
    drive(0, 32'h0, 0, 1, 32'h44, 0, 4'h0, 32'h0);
    idle(1);
    idle(0);
    // Reset in the response cycle of a load.
    drive(0, 32'h0, 0, 1, 32'h48, 0, 4'h0, 32'h0);
    rst_n = 1'b0;
    if_q.delete();
    ls_q.delete();
    streak = 0;
    idle(0);
    idle(0);
    rst_n = 1'b1;
    idle(0);
    idle(0);
    // Random traffic, including misaligned addresses.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 9) < 6, 32'($urandom_range(0, 255)), $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 6, 32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), $urandom);
    end
    idle(0);
    idle(0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
